// File: rtl/vending_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vending_pkg
//  Description : Shared types and constants for the two-product beverage
//                vending controller: state codes, coin values, prices and
//                product codes, plus a coin validity helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package vending_pkg;

    // Controller states; encoding 3 is unused
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DELIVER = 2'd1,
        ST_CHANGE  = 2'd2
    } state_e;

    // Accepted coin denominations
    localparam logic [7:0] COIN_10  = 8'd10;
    localparam logic [7:0] COIN_20  = 8'd20;
    localparam logic [7:0] COIN_50  = 8'd50;
    localparam logic [7:0] COIN_100 = 8'd100;
    localparam logic [7:0] COIN_200 = 8'd200;

    // Product prices
    localparam logic [7:0] PRICE_WATER = 8'd50;
    localparam logic [7:0] PRICE_SODA  = 8'd100;

    // Product / button codes
    localparam logic [1:0] PROD_NONE  = 2'd0;
    localparam logic [1:0] PROD_WATER = 2'd1;
    localparam logic [1:0] PROD_SODA  = 2'd2;

    // True for one of the accepted denominations; zero and odd values are rejected
    function automatic logic is_valid_coin(input logic [7:0] coin);
        return coin inside {COIN_10, COIN_20, COIN_50, COIN_100, COIN_200};
    endfunction

endpackage
`default_nettype wire

// File: rtl/vending_machine_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : vending_machine_fsm
//  Description : Coin-operated two-product beverage controller. Accumulates
//                credit, vends water or soda when credit covers the price,
//                then returns the remaining credit as change. All outputs
//                are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module vending_machine_fsm
    import vending_pkg::*;
#(
    parameter int N = 3,    // cycles beverage_out is held (N >= 1)
    parameter int M = 2     // cycles change_out is held   (M >= 1)
) (
    input  logic       clk,
    input  logic       rst,            // asynchronous, active-low
    input  logic [7:0] coin_in,
    input  logic [1:0] button_in,
    output logic [7:0] change_out,
    output logic [1:0] beverage_out,
    output logic [7:0] credit,
    output logic [1:0] state
);

    localparam logic [1:0] S_IDLE    = ST_IDLE;
    localparam logic [1:0] S_DELIVER = ST_DELIVER;
    localparam logic [1:0] S_CHANGE  = ST_CHANGE;

    localparam int C_MAX_HOLD = (N > M) ? N : M;
    localparam int C_CNT_W    = $clog2(C_MAX_HOLD + 1);

    // The counter is loaded with hold-1 and the phase ends when it reads zero,
    // so a phase lasts exactly N (or M) cycles.
    localparam logic [C_CNT_W-1:0] C_N_LOAD = C_CNT_W'(N - 1);
    localparam logic [C_CNT_W-1:0] C_M_LOAD = C_CNT_W'(M - 1);
    localparam logic [C_CNT_W-1:0] C_ONE    = C_CNT_W'(1);

    logic [1:0]         r_state;
    logic [7:0]         r_credit;
    logic [7:0]         r_change;
    logic [1:0]         r_bev;
    logic [C_CNT_W-1:0] r_cnt;

    logic [8:0]         w_sum;
    logic [7:0]         w_price;
    logic               w_btn_valid;

    // Credit sum with carry for overflow detection, and price of the pressed button
    always_comb begin
        w_sum       = {1'b0, r_credit} + {1'b0, coin_in};
        w_price     = (button_in == PROD_SODA) ? PRICE_SODA : PRICE_WATER;
        w_btn_valid = (button_in == PROD_WATER) || (button_in == PROD_SODA);
    end

    // Controller state, credit, hold counter and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_credit <= 8'd0;
            r_change <= 8'd0;
            r_bev    <= PROD_NONE;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // A product button takes priority; a coin in the same cycle is dropped
                    if (w_btn_valid) begin
                        if (r_credit >= w_price) begin
                            r_state  <= S_DELIVER;
                            r_bev    <= button_in;
                            r_credit <= r_credit - w_price;
                            r_cnt    <= C_N_LOAD;
                        end
                    end else if (button_in == PROD_NONE && is_valid_coin(coin_in) && !w_sum[8]) begin
                        r_credit <= w_sum[7:0];
                    end
                end
                S_DELIVER: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - C_ONE;
                    end else begin
                        r_bev <= PROD_NONE;
                        if (r_credit != 8'd0) begin
                            r_state  <= S_CHANGE;
                            r_change <= r_credit;
                            r_cnt    <= C_M_LOAD;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_CHANGE: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - C_ONE;
                    end else begin
                        r_change <= 8'd0;
                        r_credit <= 8'd0;
                        r_state  <= S_IDLE;
                    end
                end
                default: begin
                    // Unused encoding recovers to a quiet IDLE
                    r_state  <= S_IDLE;
                    r_bev    <= PROD_NONE;
                    r_change <= 8'd0;
                    r_cnt    <= '0;
                end
            endcase
        end
    end

    assign state        = r_state;
    assign credit       = r_credit;
    assign change_out   = r_change;
    assign beverage_out = r_bev;

endmodule
`default_nettype wire

// File: tb/tb_vending_machine_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vending_machine_fsm
//  Description : Directed self-checking bench for vending_machine_fsm with
//                N=3, M=2. Inputs change 1 ns after a rising edge and outputs
//                are checked at the same point, i.e. after each edge settles.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vending_machine_fsm;

    logic       clk;
    logic       rst;
    logic [7:0] coin_in;
    logic [1:0] button_in;
    logic [7:0] change_out;
    logic [1:0] beverage_out;
    logic [7:0] credit;
    logic [1:0] state;

    int checks;
    int errors;

    vending_machine_fsm #(.N(3), .M(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .coin_in      (coin_in),
        .button_in    (button_in),
        .change_out   (change_out),
        .beverage_out (beverage_out),
        .credit       (credit),
        .state        (state)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one cycle of input, then return inputs to idle
    task automatic apply(input logic [7:0] coin, input logic [1:0] btn);
        coin_in   = coin;
        button_in = btn;
        step();
        coin_in   = 8'd0;
        button_in = 2'd0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; coin_in = 8'd0; button_in = 2'd0;
        step();
        step();
        checks++; if (state !== 2'd0)        begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++; if (credit !== 8'd0)       begin errors++; $display("FAIL reset_credit: got %0d expected 0", credit); end
        checks++; if (change_out !== 8'd0)   begin errors++; $display("FAIL reset_change: got %0d expected 0", change_out); end
        checks++; if (beverage_out !== 2'd0) begin errors++; $display("FAIL reset_bev: got %0d expected 0", beverage_out); end
        rst = 1'b1;
    endtask

    // 50+50 then soda: exact payment, no change phase
    task automatic test_soda_exact();
        do_reset();
        apply(8'd50, 2'd0);
        checks++; if (credit !== 8'd50)  begin errors++; $display("FAIL soda_credit1: got %0d expected 50", credit); end
        apply(8'd50, 2'd0);
        checks++; if (credit !== 8'd100) begin errors++; $display("FAIL soda_credit2: got %0d expected 100", credit); end
        apply(8'd0, 2'd2);
        for (int i = 0; i < 3; i++) begin
            checks++; if (beverage_out !== 2'd2) begin errors++; $display("FAIL soda_bev[%0d]: got %0d expected 2", i, beverage_out); end
            checks++; if (state !== 2'd1)        begin errors++; $display("FAIL soda_state[%0d]: got %0d expected 1", i, state); end
            checks++; if (credit !== 8'd0)       begin errors++; $display("FAIL soda_credit_d[%0d]: got %0d expected 0", i, credit); end
            if (i < 2) step();
        end
        step();
        checks++; if (state !== 2'd0)        begin errors++; $display("FAIL soda_end_state: got %0d expected 0", state); end
        checks++; if (beverage_out !== 2'd0) begin errors++; $display("FAIL soda_end_bev: got %0d expected 0", beverage_out); end
        checks++; if (change_out !== 8'd0)   begin errors++; $display("FAIL soda_end_change: got %0d expected 0", change_out); end
    endtask

    // 200 then water: 150 change for two cycles
    task automatic test_water_change();
        do_reset();
        apply(8'd200, 2'd0);
        checks++; if (credit !== 8'd200) begin errors++; $display("FAIL water_credit: got %0d expected 200", credit); end
        apply(8'd0, 2'd1);
        for (int i = 0; i < 3; i++) begin
            checks++; if (beverage_out !== 2'd1) begin errors++; $display("FAIL water_bev[%0d]: got %0d expected 1", i, beverage_out); end
            checks++; if (credit !== 8'd150)     begin errors++; $display("FAIL water_credit_d[%0d]: got %0d expected 150", i, credit); end
            checks++; if (change_out !== 8'd0)   begin errors++; $display("FAIL water_change_d[%0d]: got %0d expected 0", i, change_out); end
            step();
        end
        for (int i = 0; i < 2; i++) begin
            checks++; if (state !== 2'd2)         begin errors++; $display("FAIL water_cstate[%0d]: got %0d expected 2", i, state); end
            checks++; if (change_out !== 8'd150)  begin errors++; $display("FAIL water_change[%0d]: got %0d expected 150", i, change_out); end
            checks++; if (beverage_out !== 2'd0)  begin errors++; $display("FAIL water_cbev[%0d]: got %0d expected 0", i, beverage_out); end
            step();
        end
        checks++; if (state !== 2'd0)      begin errors++; $display("FAIL water_end_state: got %0d expected 0", state); end
        checks++; if (credit !== 8'd0)     begin errors++; $display("FAIL water_end_credit: got %0d expected 0", credit); end
        checks++; if (change_out !== 8'd0) begin errors++; $display("FAIL water_end_change: got %0d expected 0", change_out); end
    endtask

    // Soda with only 20 credit is refused
    task automatic test_insufficient();
        do_reset();
        apply(8'd20, 2'd0);
        apply(8'd0, 2'd2);
        checks++; if (state !== 2'd0)        begin errors++; $display("FAIL insuf_state: got %0d expected 0", state); end
        checks++; if (credit !== 8'd20)      begin errors++; $display("FAIL insuf_credit: got %0d expected 20", credit); end
        checks++; if (beverage_out !== 2'd0) begin errors++; $display("FAIL insuf_bev: got %0d expected 0", beverage_out); end
    endtask

    // Invalid coin value and invalid button code are ignored
    task automatic test_invalid();
        do_reset();
        apply(8'd10, 2'd0);
        apply(8'd30, 2'd0);
        checks++; if (credit !== 8'd10) begin errors++; $display("FAIL inv_coin_credit: got %0d expected 10", credit); end
        apply(8'd0, 2'd3);
        checks++; if (state !== 2'd0)   begin errors++; $display("FAIL inv_btn_state: got %0d expected 0", state); end
        checks++; if (credit !== 8'd10) begin errors++; $display("FAIL inv_btn_credit: got %0d expected 10", credit); end
        apply(8'd50, 2'd3);
        checks++; if (credit !== 8'd10) begin errors++; $display("FAIL inv_btn_coin_credit: got %0d expected 10", credit); end
    endtask

    // Coins that would push credit past 255 are dropped without wrapping
    task automatic test_overflow();
        do_reset();
        apply(8'd200, 2'd0);
        apply(8'd50, 2'd0);
        checks++; if (credit !== 8'd250) begin errors++; $display("FAIL ovf_credit: got %0d expected 250", credit); end
        apply(8'd10, 2'd0);
        checks++; if (credit !== 8'd250) begin errors++; $display("FAIL ovf_coin10: got %0d expected 250", credit); end
        apply(8'd200, 2'd0);
        checks++; if (credit !== 8'd250) begin errors++; $display("FAIL ovf_coin200: got %0d expected 250", credit); end
    endtask

    // Coin and button together: button wins, coin is lost
    task automatic test_coin_and_button();
        do_reset();
        apply(8'd50, 2'd0);
        apply(8'd100, 2'd1);
        checks++; if (state !== 2'd1)        begin errors++; $display("FAIL cb_state: got %0d expected 1", state); end
        checks++; if (credit !== 8'd0)       begin errors++; $display("FAIL cb_credit: got %0d expected 0", credit); end
        checks++; if (beverage_out !== 2'd1) begin errors++; $display("FAIL cb_bev: got %0d expected 1", beverage_out); end
        step(); step(); step();
        checks++; if (state !== 2'd0)        begin errors++; $display("FAIL cb_end_state: got %0d expected 0", state); end
    endtask

    // Coin during delivery not credited; reset mid-change clears at once
    task automatic test_deliver_coin_and_abort();
        do_reset();
        apply(8'd100, 2'd0);
        apply(8'd0, 2'd1);
        checks++; if (credit !== 8'd50) begin errors++; $display("FAIL dc_credit0: got %0d expected 50", credit); end
        apply(8'd100, 2'd0);
        checks++; if (credit !== 8'd50) begin errors++; $display("FAIL dc_credit1: got %0d expected 50", credit); end
        step();
        step();
        checks++; if (state !== 2'd2)       begin errors++; $display("FAIL dc_cstate: got %0d expected 2", state); end
        checks++; if (change_out !== 8'd50) begin errors++; $display("FAIL dc_change: got %0d expected 50", change_out); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (state !== 2'd0)        begin errors++; $display("FAIL abort_state: got %0d expected 0", state); end
        checks++; if (credit !== 8'd0)       begin errors++; $display("FAIL abort_credit: got %0d expected 0", credit); end
        checks++; if (change_out !== 8'd0)   begin errors++; $display("FAIL abort_change: got %0d expected 0", change_out); end
        checks++; if (beverage_out !== 2'd0) begin errors++; $display("FAIL abort_bev: got %0d expected 0", beverage_out); end
        #1;
        rst = 1'b1;
        step();
        checks++; if (state !== 2'd0)        begin errors++; $display("FAIL post_abort_state: got %0d expected 0", state); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_soda_exact();
        test_water_change();
        test_insufficient();
        test_invalid();
        test_overflow();
        test_coin_and_button();
        test_deliver_coin_and_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
